// File: rtl/fft2_dout_buf.sv
// Ping-pong output buffer for a 2-D FFT: stores a frame of N2 complex samples in any order
// and streams it in ascending address order. Optional duplicate-write checking: FFT2_DOUT_BUF_DUPCHK_EN.
module fft2_dout_buf #(
    parameter  int DATA_WIDTH = 32,
    parameter  int FFT_SIZE   = 16,
    localparam int N2         = FFT_SIZE * FFT_SIZE,
    localparam int AW         = $clog2(N2)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AW-1:0]         data_o_addr_i,
    input  logic [DATA_WIDTH-1:0] dataRE_i,
    input  logic [DATA_WIDTH-1:0] dataIM_i,
    input  logic                  data_wr_i,
    output logic                  buf_ready_o,
    output logic [AW-1:0]         out_addr_o,
    output logic [DATA_WIDTH-1:0] out_re_o,
    output logic [DATA_WIDTH-1:0] out_im_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic                  out_last_o,
`ifdef FFT2_DOUT_BUF_DUPCHK_EN
    output logic                  err_dup_o,
`endif
    output logic                  err_ovf_o
);

    localparam logic [AW:0]   CNT_LAST  = (AW+1)'(N2 - 1);
    localparam logic [AW-1:0] ADDR_LAST = AW'(N2 - 1);

    typedef enum logic [1:0] {IDLE, PRIME, STREAM} rd_state_t;

    rd_state_t state, state_nxt;

    logic                    wr_bank;
    logic                    rd_bank;
    logic [1:0]              full;
    logic [AW:0]             wr_cnt;
    logic [AW-1:0]           rd_addr;
    logic [2*DATA_WIDTH-1:0] rd_data;
    logic [2*DATA_WIDTH-1:0] mem [0:2*N2-1];

    logic wr_acc;
    logic wr_done;
    logic rd_en;
    logic load_out;
    logic rd_free;

    assign buf_ready_o = ~full[wr_bank];
    assign wr_acc      = data_wr_i & buf_ready_o;
    assign wr_done     = wr_acc && (wr_cnt == CNT_LAST);
    assign out_last_o  = out_valid_o && (out_addr_o == ADDR_LAST);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // rd_data always holds the sample one address ahead of the output register, so a
    // handshake can reload the output without a bubble.
    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        load_out  = 1'b0;
        rd_free   = 1'b0;
        case (state)
            IDLE: begin
                if (full[rd_bank]) begin
                    rd_en     = 1'b1;
                    state_nxt = PRIME;
                end
            end
            PRIME: begin
                rd_en     = 1'b1;
                load_out  = 1'b1;
                state_nxt = STREAM;
            end
            STREAM: begin
                if (out_valid_o && out_ready_i) begin
                    if (out_addr_o == ADDR_LAST) begin
                        rd_free   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        rd_en    = 1'b1;
                        load_out = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: the sample memory has no reset; stale contents are never streamed because the full flags gate reads.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[{wr_bank, data_o_addr_i}] <= {dataRE_i, dataIM_i};
        if (rd_en)  rd_data <= mem[{rd_bank, rd_addr}];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank     <= 1'b0;
            rd_bank     <= 1'b0;
            full        <= 2'b00;
            wr_cnt      <= '0;
            err_ovf_o   <= 1'b0;
            rd_addr     <= '0;
            out_valid_o <= 1'b0;
            out_addr_o  <= '0;
            out_re_o    <= '0;
            out_im_o    <= '0;
        end else begin
            if (wr_acc) begin
                wr_cnt <= wr_done ? '0 : wr_cnt + (AW+1)'(1);
                if (wr_done) wr_bank <= ~wr_bank;
            end
            if (data_wr_i && !buf_ready_o) err_ovf_o <= 1'b1;

            // Writer fills one bank while the reader frees the other, so both may update together.
            for (int b = 0; b < 2; b++) begin
                if (wr_done && (wr_bank == 1'(b)))      full[b] <= 1'b1;
                else if (rd_free && (rd_bank == 1'(b))) full[b] <= 1'b0;
            end

            if (rd_en) rd_addr <= rd_addr + AW'(1);
            if (rd_free) begin
                rd_bank     <= ~rd_bank;
                rd_addr     <= '0;
                out_valid_o <= 1'b0;
            end
            if (load_out) begin
                out_valid_o <= 1'b1;
                out_addr_o  <= (state == PRIME) ? '0 : out_addr_o + AW'(1);
                out_re_o    <= rd_data[2*DATA_WIDTH-1:DATA_WIDTH];
                out_im_o    <= rd_data[DATA_WIDTH-1:0];
            end
        end
    end

`ifdef FFT2_DOUT_BUF_DUPCHK_EN
    logic [N2-1:0] wr_map [0:1];
    logic          dup_hit;

    assign dup_hit = wr_acc && wr_map[wr_bank][data_o_addr_i];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_map[0] <= '0;
            wr_map[1] <= '0;
            err_dup_o <= 1'b0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (rd_free && (rd_bank == 1'(b)))     wr_map[b] <= '0;
                else if (wr_acc && (wr_bank == 1'(b))) wr_map[b][data_o_addr_i] <= 1'b1;
            end
            if (dup_hit) err_dup_o <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fft2_dout_buf.sv
// Directed self-checking bench for fft2_dout_buf (default parameters: 32-bit samples, 256-entry frames).
module tb_fft2_dout_buf;

    localparam int DW = 32;
    localparam int N2 = 256;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] data_o_addr_i;
    logic [DW-1:0] dataRE_i;
    logic [DW-1:0] dataIM_i;
    logic          data_wr_i;
    logic          buf_ready_o;
    logic [AW-1:0] out_addr_o;
    logic [DW-1:0] out_re_o;
    logic [DW-1:0] out_im_o;
    logic          out_valid_o;
    logic          out_ready_i;
    logic          out_last_o;
    logic          err_ovf_o;
`ifdef FFT2_DOUT_BUF_DUPCHK_EN
    logic          err_dup_o;
`endif

    int errors = 0;
    int checks = 0;

    fft2_dout_buf #(.DATA_WIDTH(DW), .FFT_SIZE(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .data_o_addr_i (data_o_addr_i),
        .dataRE_i      (dataRE_i),
        .dataIM_i      (dataIM_i),
        .data_wr_i     (data_wr_i),
        .buf_ready_o   (buf_ready_o),
        .out_addr_o    (out_addr_o),
        .out_re_o      (out_re_o),
        .out_im_o      (out_im_o),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .out_last_o    (out_last_o),
`ifdef FFT2_DOUT_BUF_DUPCHK_EN
        .err_dup_o     (err_dup_o),
`endif
        .err_ovf_o     (err_ovf_o)
    );

    always #5 clk = ~clk;

    // Frame tag in the top byte lets a stale or mixed-up frame show up as a data error.
    function automatic logic [DW-1:0] exp_re(input int tag, input int a);
        logic [31:0] t;
        logic [31:0] av;
        t  = tag;
        av = a;
        return {t[7:0], 16'h0000, av[7:0]};
    endfunction

    function automatic int bitrev8(input int v);
        int r = 0;
        for (int k = 0; k < 8; k++) if (((v >> k) & 1) != 0) r |= (1 << (7 - k));
        return r;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst           = 1'b1;
        data_wr_i     = 1'b0;
        out_ready_i   = 1'b0;
        data_o_addr_i = '0;
        dataRE_i      = '0;
        dataIM_i      = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic write_frame(input int tag, input bit rev, input int n);
        for (int i = 0; i < n; i++) begin
            int a;
            a             = rev ? bitrev8(i) : i;
            data_o_addr_i = a[AW-1:0];
            dataRE_i      = exp_re(tag, a);
            dataIM_i      = ~exp_re(tag, a);
            data_wr_i     = 1'b1;
            step();
        end
        data_wr_i = 1'b0;
    endtask

    // Drains one frame, checking order, data, last flag and hold-while-stalled.
    task automatic read_frame(input int tag, input bit rnd, input string name);
        int            idx = 0;
        int            cyc = 0;
        bit            stalled = 1'b0;
        logic [AW-1:0] p_addr = '0;
        logic [DW-1:0] p_re = '0;
        logic [DW-1:0] p_im = '0;
        logic          p_last = 1'b0;
        while (idx < N2 && cyc < 5000) begin
            if (stalled) begin
                if ({out_valid_o, out_addr_o, out_re_o, out_im_o, out_last_o} !== {1'b1, p_addr, p_re, p_im, p_last}) begin
                    errors++;
                    $display("FAIL %s_stall_hold: got addr=%0d re=%h im=%h want addr=%0d re=%h im=%h",
                             name, out_addr_o, out_re_o, out_im_o, p_addr, p_re, p_im);
                end
                checks++;
            end
            out_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid_o && out_ready_i) begin
                if (out_addr_o !== idx[AW-1:0] || out_re_o !== exp_re(tag, idx) ||
                    out_im_o !== ~exp_re(tag, idx) || out_last_o !== 1'(idx == N2 - 1)) begin
                    errors++;
                    $display("FAIL %s_sample[%0d]: got addr=%0d re=%h im=%h last=%b want addr=%0d re=%h im=%h last=%b",
                             name, idx, out_addr_o, out_re_o, out_im_o, out_last_o,
                             idx, exp_re(tag, idx), ~exp_re(tag, idx), idx == N2 - 1);
                end
                checks++;
                idx++;
            end
            stalled = out_valid_o && !out_ready_i;
            p_addr  = out_addr_o;
            p_re    = out_re_o;
            p_im    = out_im_o;
            p_last  = out_last_o;
            step();
            cyc++;
        end
        if (idx < N2) begin
            errors++;
            $display("FAIL %s_timeout: got %0d samples want %0d", name, idx, N2);
        end else if (out_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL %s_valid_after_last: got %b want 0", name, out_valid_o);
        end
        checks++;
    endtask

    task automatic test_reset;
        do_reset();
        if (buf_ready_o !== 1'b1) begin errors++; $display("FAIL reset_buf_ready: got %b want 1", buf_ready_o); end
        checks++;
        if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid_o); end
        checks++;
        if (out_last_o !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b want 0", out_last_o); end
        checks++;
        if ({out_addr_o, out_re_o, out_im_o} !== '0) begin
            errors++;
            $display("FAIL reset_out_data: got addr=%0d re=%h im=%h want all 0", out_addr_o, out_re_o, out_im_o);
        end
        checks++;
        if (err_ovf_o !== 1'b0) begin errors++; $display("FAIL reset_err_ovf: got %b want 0", err_ovf_o); end
        checks++;
    endtask

    task automatic test_in_order;
        do_reset();
        out_ready_i = 1'b1;
        write_frame(0, 1'b0, N2);
        if (out_valid_o !== 1'b0) begin errors++; $display("FAIL latency_c0: got valid=%b want 0", out_valid_o); end
        checks++;
        step();
        if (out_valid_o !== 1'b0) begin errors++; $display("FAIL latency_c1: got valid=%b want 0", out_valid_o); end
        checks++;
        step();
        if (out_valid_o !== 1'b1 || out_addr_o !== 8'd0) begin
            errors++;
            $display("FAIL latency_c2: got valid=%b addr=%0d want valid=1 addr=0", out_valid_o, out_addr_o);
        end
        checks++;
        read_frame(0, 1'b0, "in_order");
    endtask

    task automatic test_bitrev;
        do_reset();
        out_ready_i = 1'b1;
        write_frame(5, 1'b1, N2);
        read_frame(5, 1'b0, "bitrev");
    endtask

    task automatic test_back_to_back;
        do_reset();
        out_ready_i = 1'b0;
        write_frame(1, 1'b0, N2);
        if (buf_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_f1: got %b want 1", buf_ready_o); end
        checks++;
        write_frame(2, 1'b0, N2);
        if (buf_ready_o !== 1'b0) begin errors++; $display("FAIL b2b_ready_after_f2: got %b want 0", buf_ready_o); end
        checks++;
        if (err_ovf_o !== 1'b0) begin errors++; $display("FAIL b2b_ovf_before_f3: got %b want 0", err_ovf_o); end
        checks++;
        write_frame(3, 1'b0, N2);
        if (err_ovf_o !== 1'b1) begin errors++; $display("FAIL b2b_ovf_after_f3: got %b want 1", err_ovf_o); end
        checks++;
        read_frame(1, 1'b0, "b2b_f1");
        read_frame(2, 1'b0, "b2b_f2");
        for (int i = 0; i < 5; i++) step();
        if (out_valid_o !== 1'b0 || buf_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_no_f3: got valid=%b ready=%b want valid=0 ready=1", out_valid_o, buf_ready_o);
        end
        checks++;
    endtask

    task automatic test_random_ready;
        do_reset();
        write_frame(4, 1'b0, N2);
        read_frame(4, 1'b1, "rand_ready");
    endtask

    task automatic test_reset_mid;
        int cyc = 0;
        do_reset();
        out_ready_i = 1'b1;
        write_frame(6, 1'b0, N2);
        while (!(out_valid_o && out_addr_o == 8'd100) && cyc < 600) begin
            step();
            cyc++;
        end
        if (cyc >= 600 || out_re_o !== exp_re(6, 100)) begin
            errors++;
            $display("FAIL mid_reach_100: got addr=%0d re=%h want addr=100 re=%h", out_addr_o, out_re_o, exp_re(6, 100));
        end
        checks++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        if (out_valid_o !== 1'b0 || buf_ready_o !== 1'b1 || out_addr_o !== 8'd0) begin
            errors++;
            $display("FAIL mid_reset_state: got valid=%b ready=%b addr=%0d want valid=0 ready=1 addr=0",
                     out_valid_o, buf_ready_o, out_addr_o);
        end
        checks++;
        write_frame(8, 1'b0, 10);
        rst = 1'b1;
        step();
        rst = 1'b0;
        write_frame(7, 1'b0, N2);
        read_frame(7, 1'b0, "after_reset");
    endtask

`ifdef FFT2_DOUT_BUF_DUPCHK_EN
    task automatic test_dup;
        do_reset();
        write_frame(9, 1'b0, 6);
        if (err_dup_o !== 1'b0) begin errors++; $display("FAIL dup_clean: got %b want 0", err_dup_o); end
        checks++;
        data_o_addr_i = 8'd5;
        data_wr_i     = 1'b1;
        step();
        data_wr_i = 1'b0;
        if (err_dup_o !== 1'b1) begin errors++; $display("FAIL dup_addr5: got %b want 1", err_dup_o); end
        checks++;
    endtask
`endif

    initial begin
        test_reset();
        test_in_order();
        test_bitrev();
        test_back_to_back();
        test_random_ready();
        test_reset_mid();
`ifdef FFT2_DOUT_BUF_DUPCHK_EN
        test_dup();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
